// File: rtl/an_corr_scheduler.sv
// an_corr_scheduler: shares one AN decoder across the tile lanes, correcting erroneous lanes lowest index first.
// Optional build macro AN_CORR_STATS_EN adds saturating block / correction / uncorrectable counters.
module an_corr_scheduler #(
    parameter int unsigned LANES   = 25,
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned MSG_W   = 13,
    parameter int unsigned DEC_LAT = 1,
    parameter int unsigned MAX_ERR = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_blk_valid,
    output logic             o_blk_ready,
    input  logic [LANES-1:0] i_err_vec,
    output logic [SEL_W-1:0] o_dec_sel,
    output logic             o_dec_req,
    input  logic [MSG_W-1:0] i_dec_msg,
    output logic             o_corr_we,
    output logic [SEL_W-1:0] o_corr_idx,
    output logic [MSG_W-1:0] o_corr_data,
    output logic             o_done_valid,
    input  logic             i_done_ready,
    output logic             o_done_uncorr,
    output logic [SEL_W:0]   o_err_cnt,
`ifdef AN_CORR_STATS_EN
    input  logic             i_stat_clr,
    output logic [15:0]      o_stat_blocks,
    output logic [15:0]      o_stat_corr,
    output logic [15:0]      o_stat_uncorr,
`endif
    output logic             o_busy
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LANES-1:0] r_pending;
    logic [LANES-1:0] w_pending_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic [SEL_W:0]   w_vec_cnt;
    logic             w_accept;
    logic             w_too_many;
    logic             w_done_hs;

    logic             r_blk_ready,   w_blk_ready_nxt;
    logic [SEL_W-1:0] r_dec_sel,     w_dec_sel_nxt;
    logic             r_dec_req,     w_dec_req_nxt;
    logic             r_corr_we,     w_corr_we_nxt;
    logic [SEL_W-1:0] r_corr_idx,    w_corr_idx_nxt;
    logic [MSG_W-1:0] r_corr_data,   w_corr_data_nxt;
    logic             r_done_valid,  w_done_valid_nxt;
    logic             r_done_uncorr, w_done_uncorr_nxt;
    logic [SEL_W:0]   r_err_cnt,     w_err_cnt_nxt;
    logic             r_busy,        w_busy_nxt;

    // Error count of the offered vector
    always_comb begin
        w_vec_cnt = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_vec_cnt = w_vec_cnt + (SEL_W+1)'(i_err_vec[i]);
        end
    end

    assign w_too_many = (w_vec_cnt > (SEL_W+1)'(MAX_ERR));
    assign w_accept   = (r_state == S_IDLE) && i_blk_valid && r_blk_ready;
    assign w_done_hs  = (r_state == S_DONE) && i_done_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((w_vec_cnt == '0) || w_too_many) w_state_nxt = S_DONE;
                    else                                 w_state_nxt = S_SEL;
                end
            end
            S_SEL:   w_state_nxt = (DEC_LAT > 0) ? S_WAIT : S_WRITE;
            S_WAIT:  if (r_wait_cnt <= CNT_W'(1)) w_state_nxt = S_WRITE;
            // the served bit is already cleared on entry to WRITE
            S_WRITE: w_state_nxt = (r_pending != '0) ? S_SEL : S_DONE;
            S_DONE:  if (i_done_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered datapath and outputs, keyed on the upcoming state
    always_comb begin
        w_pending_nxt     = r_pending;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_err_cnt_nxt     = r_err_cnt;
        w_done_uncorr_nxt = r_done_uncorr;
        w_dec_sel_nxt     = r_dec_sel;
        w_corr_idx_nxt    = r_corr_idx;
        w_corr_data_nxt   = r_corr_data;
        w_corr_we_nxt     = 1'b0;
        w_dec_req_nxt     = (w_state_nxt == S_SEL) || (w_state_nxt == S_WAIT) ||
                            (w_state_nxt == S_WRITE);
        w_done_valid_nxt  = (w_state_nxt == S_DONE);
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_blk_ready_nxt   = (w_state_nxt == S_IDLE);

        if (w_accept) begin
            w_pending_nxt     = w_too_many ? '0 : i_err_vec;
            w_err_cnt_nxt     = w_vec_cnt;
            w_done_uncorr_nxt = w_too_many;
        end
        if (w_done_hs) w_done_uncorr_nxt = 1'b0;

        if (r_state == S_SEL)       w_wait_cnt_nxt = CNT_W'(DEC_LAT);
        else if (r_state == S_WAIT) w_wait_cnt_nxt = r_wait_cnt - CNT_W'(1);

        if ((w_state_nxt == S_WRITE) && (r_state != S_WRITE)) begin
            w_pending_nxt   = r_pending & ~(LANES'(1) << r_dec_sel);
            w_corr_we_nxt   = 1'b1;
            w_corr_idx_nxt  = r_dec_sel;
            w_corr_data_nxt = i_dec_msg;
        end

        if (w_state_nxt == S_SEL) begin
            for (int i = int'(LANES) - 1; i >= 0; i--) begin
                if (w_pending_nxt[i]) w_dec_sel_nxt = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= '0;
            r_wait_cnt    <= '0;
            r_err_cnt     <= '0;
            r_done_uncorr <= 1'b0;
            r_dec_sel     <= '0;
            r_dec_req     <= 1'b0;
            r_corr_we     <= 1'b0;
            r_corr_idx    <= '0;
            r_corr_data   <= '0;
            r_done_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_blk_ready   <= 1'b0;
        end else begin
            r_pending     <= w_pending_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_err_cnt     <= w_err_cnt_nxt;
            r_done_uncorr <= w_done_uncorr_nxt;
            r_dec_sel     <= w_dec_sel_nxt;
            r_dec_req     <= w_dec_req_nxt;
            r_corr_we     <= w_corr_we_nxt;
            r_corr_idx    <= w_corr_idx_nxt;
            r_corr_data   <= w_corr_data_nxt;
            r_done_valid  <= w_done_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_blk_ready   <= w_blk_ready_nxt;
        end
    end

    assign o_blk_ready   = r_blk_ready;
    assign o_dec_sel     = r_dec_sel;
    assign o_dec_req     = r_dec_req;
    assign o_corr_we     = r_corr_we;
    assign o_corr_idx    = r_corr_idx;
    assign o_corr_data   = r_corr_data;
    assign o_done_valid  = r_done_valid;
    assign o_done_uncorr = r_done_uncorr;
    assign o_err_cnt     = r_err_cnt;
    assign o_busy        = r_busy;

`ifdef AN_CORR_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] r_stat_blocks;
    logic [STAT_W-1:0] r_stat_corr;
    logic [STAT_W-1:0] r_stat_uncorr;

    // Saturating event counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_blocks <= '0;
            r_stat_corr   <= '0;
            r_stat_uncorr <= '0;
        end else if (i_stat_clr) begin
            r_stat_blocks <= '0;
            r_stat_corr   <= '0;
            r_stat_uncorr <= '0;
        end else begin
            if (w_done_hs && (r_stat_blocks != '1))
                r_stat_blocks <= r_stat_blocks + STAT_W'(1);
            if (r_corr_we && (r_stat_corr != '1))
                r_stat_corr <= r_stat_corr + STAT_W'(1);
            if (w_done_hs && r_done_uncorr && (r_stat_uncorr != '1))
                r_stat_uncorr <= r_stat_uncorr + STAT_W'(1);
        end
    end

    assign o_stat_blocks = r_stat_blocks;
    assign o_stat_corr   = r_stat_corr;
    assign o_stat_uncorr = r_stat_uncorr;
`endif

endmodule
